// File: rtl/pc_top.sv
// ZPC display/bus node: 640x480@60 VGA timing from a 25 MHz pixel tick,
// 1bpp framebuffer fetch over the shared bus, and a per-frame mailbox write.
module pc_top #(
  parameter logic [31:0] FB_BASE      = 32'h0001_0000,
  parameter logic [31:0] MBOX_ADDR    = 32'h0000_FFFC,
  parameter int          H_ACTIVE     = 640,
  parameter int          H_SYNC_START = 656,
  parameter int          H_SYNC_END   = 752,
  parameter int          H_TOTAL      = 800,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_SYNC_START = 490,
  parameter int          V_SYNC_END   = 492,
  parameter int          V_TOTAL      = 525
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  output logic        vga_red,
  output logic        vga_green,
  output logic        vga_blue,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        INTin,
  inout  wire  [31:0] BUS,
  output logic [1:0]  Memwrite,
  output logic        Memread,
  output logic [31:0] Addr
);

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]  V_PRE   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  HS_B    = 10'(H_SYNC_START);
  localparam logic [9:0]  HS_E    = 10'(H_SYNC_END);
  localparam logic [9:0]  VS_B    = 10'(V_SYNC_START);
  localparam logic [9:0]  VS_E    = 10'(V_SYNC_END);
  localparam logic [31:0] WORDS_W = 32'(H_ACTIVE / 32);
  localparam logic [4:0]  K_LAST  = 5'(H_ACTIVE / 32 - 1);

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_RD1,
    BUS_RD2,
    BUS_WR1,
    BUS_WR2
  } bus_state_e;

  logic        phase_q;
  logic        tick;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        visible_n, load;
  logic [31:0] shift_q, shift_d, hold_q, hold_d;
  logic        pix_q, pix_d, hs_q, hs_d, vs_q, vs_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  bus_state_e  state_q, state_d;
  logic        rd_pend_q, rd_pend_d, wr_pend_q, wr_pend_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        rd_req, wr_req;
  logic [31:0] fetch_word, rd_req_addr;
  logic        mr_q, mr_d, int_q, int_d, oe_q, oe_d;
  logic [1:0]  mw_q, mw_d;
  logic [31:0] addr_q, addr_d, dout_q, dout_d;

  assign tick = phase_q;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Everything below keys off the position the current tick moves to, so the
  // registered outputs line up with the new h/v on the same edge.
  assign visible_n = (h_d < H_ACT) && (v_d < V_ACT);
  assign load      = tick && visible_n && (h_d[4:0] == 5'd0);

  always_comb begin
    shift_d = shift_q;
    pix_d   = pix_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    if (tick) begin
      shift_d = load ? hold_q : {shift_q[30:0], 1'b0};
      pix_d   = visible_n & shift_d[31];
      hs_d    = !((h_d >= HS_B) && (h_d < HS_E));
      vs_d    = !((v_d >= VS_B) && (v_d < VS_E));
    end
  end

  // Next word of this line on each load; word 0 of the next line at the end
  // of the visible part, with line 0 prefetched from the last blank line.
  always_comb begin
    rd_req     = 1'b0;
    fetch_word = '0;
    if (load && (h_d[9:5] < K_LAST)) begin
      rd_req     = 1'b1;
      fetch_word = {22'd0, v_d} * WORDS_W + {27'd0, h_d[9:5]} + 32'd1;
    end else if (tick && (h_d == H_ACT) && (v_d < V_PRE)) begin
      rd_req     = 1'b1;
      fetch_word = ({22'd0, v_d} + 32'd1) * WORDS_W;
    end else if (tick && (h_d == H_ACT) && (v_d == V_LAST)) begin
      rd_req     = 1'b1;
      fetch_word = '0;
    end
    rd_req_addr = FB_BASE + {fetch_word[29:0], 2'b00};
  end

  assign wr_req = tick && (h_d == 10'd0) && (v_d == V_ACT);

  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_pend_q | rd_req;
    rd_addr_d   = rd_req ? rd_req_addr : rd_addr_q;
    wr_pend_d   = wr_pend_q | wr_req;
    frame_cnt_d = frame_cnt_q;
    hold_d      = hold_q;
    mr_d        = 1'b0;
    mw_d        = 2'b00;
    oe_d        = 1'b0;
    int_d       = 1'b0;
    addr_d      = addr_q;
    dout_d      = dout_q;
    case (state_q)
      BUS_IDLE, BUS_RD2, BUS_WR2: begin
        if (state_q == BUS_RD2) hold_d = BUS;
        if (state_q == BUS_WR2) frame_cnt_d = frame_cnt_q + 32'd1;
        // A pending write always goes first; a read waits behind it.
        if (wr_pend_d) begin
          state_d   = BUS_WR1;
          wr_pend_d = 1'b0;
          mw_d      = 2'b11;
          oe_d      = 1'b1;
          int_d     = 1'b1;
          addr_d    = MBOX_ADDR;
          dout_d    = frame_cnt_d;
        end else if (rd_pend_d) begin
          state_d   = BUS_RD1;
          rd_pend_d = 1'b0;
          mr_d      = 1'b1;
          addr_d    = rd_addr_d;
        end else begin
          state_d = BUS_IDLE;
        end
      end
      BUS_RD1: begin
        state_d = BUS_RD2;
        mr_d    = 1'b1;
      end
      BUS_WR1: begin
        state_d = BUS_WR2;
        mw_d    = 2'b11;
        oe_d    = 1'b1;
        int_d   = 1'b1;
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      phase_q     <= 1'b0;
      h_q         <= '0;
      v_q         <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      pix_q       <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      frame_cnt_q <= '0;
      state_q     <= BUS_IDLE;
      rd_pend_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      mr_q        <= 1'b0;
      mw_q        <= 2'b00;
      oe_q        <= 1'b0;
      int_q       <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
    end else begin
      phase_q     <= ~phase_q;
      h_q         <= h_d;
      v_q         <= v_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      pix_q       <= pix_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      frame_cnt_q <= frame_cnt_d;
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      wr_pend_q   <= wr_pend_d;
      rd_addr_q   <= rd_addr_d;
      mr_q        <= mr_d;
      mw_q        <= mw_d;
      oe_q        <= oe_d;
      int_q       <= int_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
    end
  end

  assign BUS       = oe_q ? dout_q : 32'bz;
  assign vga_red   = pix_q;
  assign vga_green = pix_q;
  assign vga_blue  = pix_q;
  assign vga_hsync = hs_q;
  assign vga_vsync = vs_q;
  assign INTin     = int_q;
  assign Memwrite  = mw_q;
  assign Memread   = mr_q;
  assign Addr      = addr_q;

endmodule

// File: tb/tb_pc_top.sv
// Bench for pc_top: a shrunk-geometry instance checked cycle by cycle against
// a position-arithmetic model, plus a default-geometry instance for addressing.
module tb_pc_top;

  localparam logic [31:0] FB = 32'h0001_0000;
  localparam logic [31:0] MB = 32'h0000_FFFC;
  localparam int HT = 96, HA = 64, HSB = 72, HSE = 80;
  localparam int VT = 13, VA = 8, VSB = 10, VSE = 12;
  localparam int W = HA / 32, NW = W * VA;
  localparam int FRAME = 2 * HT * VT;
  localparam int WR_C  = 2 * VA * HT;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_s, rst_d;
  wire  [31:0] bus_s, bus_d;
  logic r_s, g_s, b_s, hs_s, vs_s, int_s, mr_s;
  logic r_d, g_d, b_d, hs_d, vs_d, int_d, mr_d;
  logic [1:0]  mw_s, mw_d;
  logic [31:0] addr_s, addr_d;
  logic [31:0] mem_s [NW];

  for (genvar i = 0; i < 32; i++) begin : g_pu
    pullup (bus_s[i]);
    pullup (bus_d[i]);
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a >= FB && a < FB + 32'(4 * NW)) return mem_s[int'((a - FB) >> 2)];
    return a;
  endfunction

  assign bus_s = mr_s ? mem_rd(addr_s) : 32'bz;
  assign bus_d = mr_d ? addr_d : 32'bz;

  pc_top #(.FB_BASE(FB), .MBOX_ADDR(MB), .H_ACTIVE(HA), .H_SYNC_START(HSB),
           .H_SYNC_END(HSE), .H_TOTAL(HT), .V_ACTIVE(VA), .V_SYNC_START(VSB),
           .V_SYNC_END(VSE), .V_TOTAL(VT)) dut_s (
    .clk_50mhz(clk), .rst(rst_s), .vga_red(r_s), .vga_green(g_s), .vga_blue(b_s),
    .vga_hsync(hs_s), .vga_vsync(vs_s), .INTin(int_s), .BUS(bus_s),
    .Memwrite(mw_s), .Memread(mr_s), .Addr(addr_s));

  pc_top dut_d (
    .clk_50mhz(clk), .rst(rst_d), .vga_red(r_d), .vga_green(g_d), .vga_blue(b_d),
    .vga_hsync(hs_d), .vga_vsync(vs_d), .INTin(int_d), .BUS(bus_d),
    .Memwrite(mw_d), .Memread(mr_d), .Addr(addr_d));

  int c_s, c_d;
  always @(posedge clk or posedge rst_s) if (rst_s) c_s <= 0; else c_s <= c_s + 1;
  always @(posedge clk or posedge rst_d) if (rst_d) c_d <= 0; else c_d <= c_d + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pixel expected at tick position p counted from reset release.
  function automatic logic exp_pix(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    if (h >= HA || v >= VA) return 1'b0;
    return mem_s[v * W + h / 32][31 - h % 32];
  endfunction

  task automatic check_rst_s(input string tag);
    chk({tag, "_red"}, r_s, 0);   chk({tag, "_green"}, g_s, 0);
    chk({tag, "_blue"}, b_s, 0);  chk({tag, "_hsync"}, hs_s, 1);
    chk({tag, "_vsync"}, vs_s, 1); chk({tag, "_intin"}, int_s, 0);
    chk({tag, "_memwrite"}, mw_s, 0); chk({tag, "_memread"}, mr_s, 0);
    chk({tag, "_addr"}, addr_s, 0); chk({tag, "_bus_released"}, bus_s, 32'hFFFF_FFFF);
  endtask

  // Cycle-by-cycle monitor of the small instance.
  int   p_m, h_m, v_m, run_s, rdi_s, vfall_s, rdcnt_s;
  logic ew_m, mrp_s, vsp_s;
  always @(negedge clk) begin
    if (rst_s) begin
      mrp_s = 1'b0; run_s = 0; rdi_s = 0; vsp_s = 1'b1; vfall_s = -1; rdcnt_s = 0;
    end else begin
      p_m = c_s / 2;
      h_m = p_m % HT;
      v_m = (p_m / HT) % VT;
      chk("hsync", hs_s, (h_m >= HSB && h_m < HSE) ? 0 : 1);
      chk("vsync", vs_s, (v_m >= VSB && v_m < VSE) ? 0 : 1);
      if (p_m >= HT) begin
        chk("red", r_s, exp_pix(p_m));
        chk("green", g_s, exp_pix(p_m));
        chk("blue", b_s, exp_pix(p_m));
      end
      ew_m = (c_s >= WR_C) && (((c_s - WR_C) % FRAME) < 2);
      chk("memwrite", mw_s, ew_m ? 3 : 0);
      chk("intin", int_s, ew_m);
      if (ew_m) begin
        chk("wr_addr", addr_s, MB);
        chk("wr_data", bus_s, (c_s - WR_C) / FRAME);
      end
      if (mr_s) begin
        chk("rd_no_write", mw_s, 0);
        run_s++;
        if (!mrp_s) begin
          chk("rd_addr", addr_s, FB + 32'(4 * ((2 + rdi_s) % NW)));
          rdi_s++;
          rdcnt_s++;
        end
      end else if (mrp_s) begin
        chk("rd_len", run_s, 2);
        run_s = 0;
      end
      mrp_s = mr_s;
      if (!vs_s && vsp_s) begin
        if (vfall_s >= 0) begin
          chk("frame_period", c_s - vfall_s, FRAME);
          chk("reads_per_frame", rdcnt_s, NW);
        end
        vfall_s = c_s;
        rdcnt_s = 0;
      end
      if (vs_s && !vsp_s) chk("vsync_len", c_s - vfall_s, 4 * HT);
      vsp_s = vs_s;
    end
  end

  // Default-geometry instance: read address stream and hsync shape.
  int   rdi_d, hfall_d;
  logic mrp_d, hsp_d;
  always @(negedge clk) begin
    if (rst_d) begin
      rdi_d = 0; hfall_d = 0; mrp_d = 1'b0; hsp_d = 1'b1;
    end else begin
      chk("d_memwrite", mw_d, 0);
      if (mr_d && !mrp_d) begin
        chk("d_rd_addr", addr_d, FB + 32'(4 * ((2 + rdi_d) % 9600)));
        if (rdi_d == 18) chk("d_line1_word0", addr_d, 32'h0001_0050);
        rdi_d++;
      end
      mrp_d = mr_d;
      if (!hs_d && hsp_d) begin
        chk("d_hsync_fall", c_d % 1600, 1312);
        hfall_d = c_d;
      end
      if (hs_d && !hsp_d) chk("d_hsync_len", c_d - hfall_d, 192);
      hsp_d = hs_d;
      if (c_d == 3400) chk("d_read_count", rdi_d, 43);
    end
  end

  typedef struct {
    int          cyc;
    logic        hs, vs, col, mr;
    logic [1:0]  mw;
    logic        intr, ca;
    logic [31:0] addr;
  } vec_t;
  vec_t tv[21];
  int   tgt[5];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_s = 1'b1;
    rst_d = 1'b1;
    foreach (mem_s[i]) mem_s[i] = $urandom;
    mem_s[0] = 32'hA000_0000;

    tv[0]  = '{2,    1, 1, 0, 0, 2'b00, 0, 1, 32'h0};
    tv[1]  = '{128,  1, 1, 0, 1, 2'b00, 0, 1, FB + 8};
    tv[2]  = '{129,  1, 1, 0, 1, 2'b00, 0, 1, FB + 8};
    tv[3]  = '{130,  1, 1, 0, 0, 2'b00, 0, 1, FB + 8};
    tv[4]  = '{143,  1, 1, 0, 0, 2'b00, 0, 0, 32'h0};
    tv[5]  = '{144,  0, 1, 0, 0, 2'b00, 0, 0, 32'h0};
    tv[6]  = '{159,  0, 1, 0, 0, 2'b00, 0, 0, 32'h0};
    tv[7]  = '{160,  1, 1, 0, 0, 2'b00, 0, 0, 32'h0};
    tv[8]  = '{1536, 1, 1, 0, 0, 2'b11, 1, 1, MB};
    tv[9]  = '{1537, 1, 1, 0, 0, 2'b11, 1, 1, MB};
    tv[10] = '{1538, 1, 1, 0, 0, 2'b00, 0, 1, MB};
    tv[11] = '{1919, 1, 1, 0, 0, 2'b00, 0, 0, 32'h0};
    tv[12] = '{1920, 1, 0, 0, 0, 2'b00, 0, 0, 32'h0};
    tv[13] = '{2303, 1, 0, 0, 0, 2'b00, 0, 0, 32'h0};
    tv[14] = '{2304, 1, 1, 0, 0, 2'b00, 0, 0, 32'h0};
    tv[15] = '{2432, 1, 1, 0, 1, 2'b00, 0, 1, FB};
    tv[16] = '{2496, 1, 1, 1, 1, 2'b00, 0, 1, FB + 4};
    tv[17] = '{2498, 1, 1, 0, 0, 2'b00, 0, 1, FB + 4};
    tv[18] = '{2500, 1, 1, 1, 0, 2'b00, 0, 1, FB + 4};
    tv[19] = '{2502, 1, 1, 0, 0, 2'b00, 0, 1, FB + 4};
    tv[20] = '{2624, 1, 1, 0, 1, 2'b00, 0, 1, FB + 8};

    repeat (3) @(posedge clk);
    #1;
    check_rst_s("rst");
    chk("d_rst_red", r_d, 0);       chk("d_rst_hsync", hs_d, 1);
    chk("d_rst_vsync", vs_d, 1);    chk("d_rst_memread", mr_d, 0);
    chk("d_rst_addr", addr_d, 0);   chk("d_rst_bus_released", bus_d, 32'hFFFF_FFFF);
    rst_s = 1'b0;
    rst_d = 1'b0;

    for (int i = 0; i < 21; i++) begin
      while (c_s < tv[i].cyc) begin @(posedge clk); #1; end
      chk($sformatf("vec%0d_hsync", i), hs_s, tv[i].hs);
      chk($sformatf("vec%0d_vsync", i), vs_s, tv[i].vs);
      chk($sformatf("vec%0d_red", i), r_s, tv[i].col);
      chk($sformatf("vec%0d_green", i), g_s, tv[i].col);
      chk($sformatf("vec%0d_blue", i), b_s, tv[i].col);
      chk($sformatf("vec%0d_memread", i), mr_s, tv[i].mr);
      chk($sformatf("vec%0d_memwrite", i), mw_s, tv[i].mw);
      chk($sformatf("vec%0d_intin", i), int_s, tv[i].intr);
      if (tv[i].ca) chk($sformatf("vec%0d_addr", i), addr_s, tv[i].addr);
    end

    while (c_s < 3 * FRAME + 10) begin @(posedge clk); #1; end

    rst_s = 1'b1;
    #1;
    check_rst_s("pulse");
    @(posedge clk);
    #1;
    rst_s = 1'b0;

    tgt[0] = 1537;
    tgt[1] = 129;
    for (int i = 2; i < 5; i++) tgt[i] = $urandom_range(3, 2 * FRAME);
    for (int i = 0; i < 5; i++) begin
      while (c_s < tgt[i]) begin @(posedge clk); #1; end
      if (i == 0) chk("pre_rst_write", mw_s, 3);
      if (i == 1) chk("pre_rst_read", mr_s, 1);
      rst_s = 1'b1;
      #1;
      check_rst_s($sformatf("mid%0d", i));
      @(posedge clk);
      #1;
      foreach (mem_s[j]) mem_s[j] = $urandom;
      rst_s = 1'b0;
    end

    while (c_s < FRAME + 50) begin @(posedge clk); #1; end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
